// File: rtl/matrix_scan_driver_pkg.sv
// Shared definitions for the LED matrix scan driver: FSM state encoding,
// default geometry and a width helper for counters.
package matrix_scan_driver_pkg;

   typedef enum logic [1:0] {
      ST_BLANK = 2'd0,
      ST_LATCH = 2'd1,
      ST_SHOW  = 2'd2
   } scan_state_t;

   localparam int unsigned DEF_N_COLS = 5;
   localparam int unsigned DEF_N_ROWS = 7;

   // Counter width for a modulus n, never narrower than one bit
   function automatic int unsigned width_of(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/matrix_scan_driver_prescaler.sv
// Mod-DIV column prescaler: counts while i_run is high, clears otherwise,
// o_tc flags the last count of a running period.
module matrix_scan_driver_prescaler
   import matrix_scan_driver_pkg::*;
#(
   parameter int unsigned DIV = 1000
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_run,
   output logic o_tc
);

   localparam int unsigned PW = width_of(DIV);
   localparam logic [PW-1:0] LAST = PW'(DIV - 1);

   logic [PW-1:0] r_cnt;

   assign o_tc = i_run && (r_cnt == LAST);

   always_ff @(posedge i_clk) begin
      if (i_reset || !i_run || o_tc) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/matrix_scan_driver.sv
// Column-multiplexed 7x5 LED matrix scan driver (BLANK -> LATCH -> SHOW per column).
// Optional blink map alternation enabled by defining MATRIX_SCAN_BLINK_EN.
module matrix_scan_driver
   import matrix_scan_driver_pkg::*;
#(
   parameter  int unsigned N_COLS       = DEF_N_COLS,
   parameter  int unsigned N_ROWS       = DEF_N_ROWS,
   parameter  int unsigned SCAN_DIV     = 1000,
   parameter  int unsigned BLINK_FRAMES = 50,
   localparam int unsigned CW           = width_of(N_COLS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic [N_ROWS-1:0] row_in,
   output logic [CW-1:0]     col_idx,
   output logic [N_COLS-1:0] col_n,
   output logic [N_ROWS-1:0] row,
   output logic              map_sel,
   output logic              frame_done
);

   if (SCAN_DIV < 1 || BLINK_FRAMES < 1) begin : g_bad_param
      $error("matrix_scan_driver: SCAN_DIV and BLINK_FRAMES must be >= 1");
   end

   scan_state_t       r_state;
   logic [CW-1:0]     r_col_idx;
   logic [N_COLS-1:0] r_col_n;
   logic [N_ROWS-1:0] r_row;
   logic              r_frame_done;
   logic              w_run;
   logic              w_tc;
   logic              w_last_col;
   logic              w_frame_end;

   assign w_run       = enable && (r_state == ST_SHOW);
   assign w_last_col  = (r_col_idx == CW'(N_COLS - 1));
   assign w_frame_end = w_tc && w_last_col;

   matrix_scan_driver_prescaler #(
      .DIV (SCAN_DIV)
   ) u_prescaler (
      .i_clk   (clk),
      .i_reset (reset),
      .i_run   (w_run),
      .o_tc    (w_tc)
   );

   // r_row doubles as the latched row pattern; it is zeroed whenever the column is dark
   always_ff @(posedge clk) begin
      if (reset || !enable) begin
         r_state      <= ST_BLANK;
         r_col_idx    <= '0;
         r_col_n      <= '1;
         r_row        <= '0;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= 1'b0;
         case (r_state)
            ST_BLANK: r_state <= ST_LATCH;
            ST_LATCH: begin
               r_state <= ST_SHOW;
               r_col_n <= ~(N_COLS'(1) << r_col_idx);
               r_row   <= row_in;
            end
            ST_SHOW: begin
               if (w_tc) begin
                  r_state      <= ST_BLANK;
                  r_col_n      <= '1;
                  r_row        <= '0;
                  r_col_idx    <= w_last_col ? '0 : r_col_idx + 1'b1;
                  r_frame_done <= w_last_col;
               end
            end
            default: r_state <= ST_BLANK;
         endcase
      end
   end

`ifdef MATRIX_SCAN_BLINK_EN
   localparam int unsigned FW = width_of(BLINK_FRAMES);

   logic [FW-1:0] r_frame_cnt;
   logic          r_map_sel;

   // Toggles on the same edge col_idx wraps, so every frame uses a single map
   always_ff @(posedge clk) begin
      if (reset) begin
         r_frame_cnt <= '0;
         r_map_sel   <= 1'b0;
      end else if (w_frame_end) begin
         if (r_frame_cnt == FW'(BLINK_FRAMES - 1)) begin
            r_frame_cnt <= '0;
            r_map_sel   <= ~r_map_sel;
         end else begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
         end
      end
   end

   assign map_sel = r_map_sel;
`else
   assign map_sel = 1'b0;
`endif

   assign col_idx    = r_col_idx;
   assign col_n      = r_col_n;
   assign row        = r_row;
   assign frame_done = r_frame_done;

endmodule
